imem_loader: RTL and testbench

- Writer side of the instruction-fetch path. Accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit instruction words. Writes each word into instruction memory at consecutive byte addresses starting at 0.
- Holds the single-cycle datapath (core_hold) while loading, so a program can be loaded before PC starts at 0.

---
 rtl/imem_loader.sv | 162 ++++++++++++++++
 tb/tb_imem_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: packs bytes little-endian into 32-bit words and
// writes them to instruction memory from address 0 while holding the core.
module imem_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int PC_WIDTH   = 64
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                start,
   input  logic [ADDR_WIDTH:0] len_words,
   input  logic                abort,
   input  logic [7:0]          byte_in,
   input  logic                byte_valid,
   output logic                byte_ready,
   output logic                imem_we,
   output logic [PC_WIDTH-1:0] imem_waddr,
   output logic [31:0]         imem_wdata,
   output logic                core_hold,
   output logic                done,
   output logic                error
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WRITE,
      ST_DONE
   } state_t;

   localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_t              state;
   state_t              state_next;
   logic [ADDR_WIDTH:0] len_q;
   logic [ADDR_WIDTH:0] word_cnt;
   logic [ADDR_WIDTH:0] word_cnt_inc;
   logic [1:0]          byte_idx;
   logic [31:0]         shift_reg;
   logic                we_q;
   logic                last_word;

   // word_cnt is one bit wider than the word address so a full-capacity load
   // reaches len without wrapping.
   assign word_cnt_inc = word_cnt + (ADDR_WIDTH+1)'(1);
   assign last_word    = (word_cnt_inc == len_q);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (len_words > CAPACITY) begin
                  state_next = ST_IDLE;
               end else if (len_words == '0) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else if (byte_valid && (byte_idx == 2'd3)) begin
               state_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else if (last_word) begin
               state_next = ST_DONE;
            end else begin
               state_next = ST_LOAD;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Status outputs are registered from the next state so they track the
   // state register exactly, without decode glitches.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         byte_ready <= 1'b0;
         we_q       <= 1'b0;
         core_hold  <= 1'b0;
         done       <= 1'b0;
      end else begin
         byte_ready <= (state_next == ST_LOAD);
         we_q       <= (state_next == ST_WRITE);
         core_hold  <= (state_next == ST_LOAD) || (state_next == ST_WRITE);
         done       <= (state_next == ST_DONE);
      end
   end

   // An abort arriving during the write cycle must suppress that write.
   assign imem_we = we_q && !abort;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         len_q      <= '0;
         word_cnt   <= '0;
         byte_idx   <= '0;
         shift_reg  <= '0;
         imem_waddr <= '0;
         imem_wdata <= '0;
         error      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (len_words > CAPACITY) begin
                     error <= 1'b1;
                  end else begin
                     len_q    <= len_words;
                     word_cnt <= '0;
                     byte_idx <= '0;
                     error    <= 1'b0;
                  end
               end
            end
            ST_LOAD: begin
               if (abort) begin
                  error <= 1'b1;
               end else if (byte_valid) begin
                  shift_reg <= {byte_in, shift_reg[31:8]};
                  byte_idx  <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     imem_wdata <= {byte_in, shift_reg[31:8]};
                     imem_waddr <= PC_WIDTH'({word_cnt, 2'b00});
                  end
               end
            end
            ST_WRITE: begin
               if (abort) begin
                  error <= 1'b1;
               end else begin
                  word_cnt <= word_cnt_inc;
                  byte_idx <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes and done pulses are queued
// by the stimulus and consumed by an independent monitor.
module tb_imem_loader;

   localparam int ADDR_WIDTH = 2;
   localparam int PC_WIDTH   = 64;

   typedef logic [7:0] byte_q_t[$];
   typedef struct {
      logic [63:0] addr;
      logic [31:0] data;
   } wr_t;

   logic                clock = 1'b0;
   logic                reset_n;
   logic                start;
   logic [ADDR_WIDTH:0] len_words;
   logic                abort;
   logic [7:0]          byte_in;
   logic                byte_valid;
   logic                byte_ready;
   logic                imem_we;
   logic [PC_WIDTH-1:0] imem_waddr;
   logic [31:0]         imem_wdata;
   logic                core_hold;
   logic                done;
   logic                error;

   int  checks = 0;
   int  errors = 0;
   int  cyc    = 0;
   wr_t exp_wr[$];
   int  exp_done[$];

   imem_loader #(.ADDR_WIDTH(ADDR_WIDTH), .PC_WIDTH(PC_WIDTH)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .len_words(len_words),
      .abort(abort), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata), .core_hold(core_hold), .done(done), .error(error)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: word w of a load is bytes 4w..4w+3 little-endian at byte address 4w.
   function automatic void push_model(input int nwords, input byte_q_t bytes);
      wr_t w;
      for (int i = 0; i < nwords; i++) begin
         w.addr = 64'(i * 4);
         w.data = '0;
         for (int b = 0; b < 4; b++) begin
            w.data = w.data | (32'(bytes[4*i+b]) << (8*b));
         end
         exp_wr.push_back(w);
      end
   endfunction

   function automatic byte_q_t random_bytes(input int n);
      byte_q_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
      return q;
   endfunction

   // Entered and left at a falling edge; mode 0 = valid held, 1 = 1,0,0,1 pattern, 2 = random.
   task automatic applyStimulus(input byte_q_t bytes, input int mode);
      int idx = 0;
      int k = 0;
      int budget = 10 * bytes.size() + 40;
      bit acc;
      while (idx < bytes.size() && k < budget) begin
         byte_in = bytes[idx];
         case (mode)
            0:       byte_valid = 1'b1;
            1:       byte_valid = ((k % 4) == 0) || ((k % 4) == 3);
            default: byte_valid = 1'($urandom_range(0, 1));
         endcase
         checkOutput("core_hold_busy", 64'(core_hold), 64'd1);
         acc = byte_valid && byte_ready;
         @(posedge clock);
         if (acc) idx++;
         k++;
         @(negedge clock);
      end
      byte_valid = 1'b0;
      if (idx < bytes.size()) checkOutput("stream_timeout", 64'(idx), 64'(bytes.size()));
   endtask

   task automatic run_load(input int len, input byte_q_t bytes, input int mode);
      @(negedge clock);
      start     = 1'b1;
      len_words = (ADDR_WIDTH+1)'(len);
      push_model(len, bytes);
      exp_done.push_back((mode == 0) ? (cyc + 1 + 5 * len) : -1);
      @(negedge clock);
      start = 1'b0;
      if (len > 0) begin
         applyStimulus(bytes, mode);
         repeat (2) @(negedge clock);
      end else begin
         repeat (2) @(negedge clock);
      end
      checkOutput("idle_core_hold", 64'(core_hold), 64'd0);
      checkOutput("load_error", 64'(error), 64'd0);
      checkOutput("pending_writes", 64'(exp_wr.size()), 64'd0);
      checkOutput("pending_done", 64'(exp_done.size()), 64'd0);
   endtask

   // Monitor: every write and done pulse must match the head of its queue.
   initial begin : monitor
      wr_t w;
      int  e;
      forever begin
         @(negedge clock);
         #1;
         if (reset_n) begin
            if (imem_we) begin
               if (exp_wr.size() == 0) begin
                  checkOutput("unexpected_write", imem_waddr, 64'hFFFF_FFFF_FFFF_FFFF);
               end else begin
                  w = exp_wr.pop_front();
                  checkOutput("waddr", imem_waddr, w.addr);
                  checkOutput("wdata", 64'(imem_wdata), 64'(w.data));
               end
            end
            if (done) begin
               if (exp_done.size() == 0) begin
                  checkOutput("unexpected_done", 64'(cyc), 64'hFFFF_FFFF_FFFF_FFFF);
               end else begin
                  e = exp_done.pop_front();
                  if (e >= 0) checkOutput("done_cycle", 64'(cyc), 64'(e));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   initial begin : main
      byte_q_t prog;
      byte_q_t q;
      byte_q_t part;
      byte_q_t none;
      reset_n = 1'b0; start = 1'b0; len_words = '0; abort = 1'b0;
      byte_in = '0; byte_valid = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput("rst_byte_ready", 64'(byte_ready), 64'd0);
      checkOutput("rst_imem_we", 64'(imem_we), 64'd0);
      checkOutput("rst_waddr", imem_waddr, 64'd0);
      checkOutput("rst_wdata", 64'(imem_wdata), 64'd0);
      checkOutput("rst_core_hold", 64'(core_hold), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_error", 64'(error), 64'd0);
      reset_n = 1'b1;

      $display("[TB] program load, valid held high");
      prog = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
      run_load(2, prog, 0);

      $display("[TB] program load with valid gaps");
      run_load(2, prog, 1);

      $display("[TB] zero-length load");
      run_load(0, none, 0);

      $display("[TB] oversize length");
      @(negedge clock);
      start = 1'b1;
      len_words = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) + 1);
      @(negedge clock);
      start = 1'b0;
      checkOutput("badlen_error", 64'(error), 64'd1);
      checkOutput("badlen_core_hold", 64'(core_hold), 64'd0);
      checkOutput("badlen_byte_ready", 64'(byte_ready), 64'd0);
      @(negedge clock);
      checkOutput("badlen_stay_idle", 64'(core_hold), 64'd0);

      $display("[TB] full-capacity load clears error");
      q = random_bytes(4 << ADDR_WIDTH);
      run_load(1 << ADDR_WIDTH, q, 0);

      $display("[TB] abort in IDLE");
      @(negedge clock);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      checkOutput("idle_abort_error", 64'(error), 64'd0);

      $display("[TB] abort after 6 bytes of a 3-word load");
      q = random_bytes(12);
      part = {};
      for (int i = 0; i < 6; i++) part.push_back(q[i]);
      @(negedge clock);
      start = 1'b1;
      len_words = 3'd3;
      push_model(1, q);
      @(negedge clock);
      start = 1'b0;
      applyStimulus(part, 0);
      abort = 1'b1;
      byte_valid = 1'b1;
      byte_in = 8'hAA;
      @(negedge clock);
      abort = 1'b0;
      byte_valid = 1'b0;
      checkOutput("abort_error", 64'(error), 64'd1);
      checkOutput("abort_core_hold", 64'(core_hold), 64'd0);
      checkOutput("abort_byte_ready", 64'(byte_ready), 64'd0);
      repeat (2) @(negedge clock);
      checkOutput("abort_pending_writes", 64'(exp_wr.size()), 64'd0);

      $display("[TB] reload after abort");
      q = random_bytes(8);
      run_load(2, q, 0);

      $display("[TB] abort during write cycle");
      q = random_bytes(8);
      part = {};
      for (int i = 0; i < 4; i++) part.push_back(q[i]);
      @(negedge clock);
      start = 1'b1;
      len_words = 3'd2;
      @(negedge clock);
      start = 1'b0;
      applyStimulus(part, 0);
      abort = 1'b1;
      #2;
      checkOutput("abort_write_we", 64'(imem_we), 64'd0);
      @(negedge clock);
      abort = 1'b0;
      checkOutput("abort_write_error", 64'(error), 64'd1);
      checkOutput("abort_write_core_hold", 64'(core_hold), 64'd0);

      $display("[TB] asynchronous reset mid-word");
      q = random_bytes(8);
      part = {};
      for (int i = 0; i < 2; i++) part.push_back(q[i]);
      @(negedge clock);
      start = 1'b1;
      len_words = 3'd2;
      @(negedge clock);
      start = 1'b0;
      applyStimulus(part, 0);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("arst_byte_ready", 64'(byte_ready), 64'd0);
      checkOutput("arst_imem_we", 64'(imem_we), 64'd0);
      checkOutput("arst_waddr", imem_waddr, 64'd0);
      checkOutput("arst_wdata", 64'(imem_wdata), 64'd0);
      checkOutput("arst_core_hold", 64'(core_hold), 64'd0);
      checkOutput("arst_done", 64'(done), 64'd0);
      checkOutput("arst_error", 64'(error), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      q = random_bytes(8);
      run_load(2, q, 0);

      $display("[TB] randomized loads");
      for (int n = 0; n < 6; n++) begin
         int len;
         int mode;
         len  = $urandom_range(1, 1 << ADDR_WIDTH);
         mode = $urandom_range(0, 2);
         q = random_bytes(4 * len);
         run_load(len, q, mode);
      end

      repeat (3) @(negedge clock);
      checkOutput("final_pending_writes", 64'(exp_wr.size()), 64'd0);
      checkOutput("final_pending_done", 64'(exp_done.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
